division_requester: RTL and testbench

- Host-side driver for the iterative fixed-point Division block. It is the other end of the Division in_valid/out_valid interface.
- Accepts divide jobs (10-bit dividend, 3-bit divisor) on a valid/ready request port and runs exactly one Division transaction per job.
- Captures the 20-bit quotient (10 integer . 10 fractional bits) and returns it on a valid/ready response port, with an error flag and a measured latency.
- Handles divide-by-zero locally and enforces Division's operand-hold and re-arm rules.

---
 rtl/division_requester_if.sv | 34 +++
 rtl/division_requester.sv | 111 +++++++++++
 tb/tb_division_requester.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/division_requester_if.sv
// Request/response and Division-side signals of the division requester.
// slave is the requester's view; master is the host/Division side.
interface division_requester_if #(
    parameter int LAT_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [9:0]       req_dividend;
    logic [2:0]       req_divisor;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [19:0]      rsp_quotient;
    logic             rsp_err;
    logic [LAT_W-1:0] rsp_cycles;
    logic             div_in_valid;
    logic [9:0]       div_in_data_1;
    logic [2:0]       div_in_data_2;
    logic             div_out_valid;
    logic [19:0]      div_out_data;

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        input  rsp_ready, div_out_valid, div_out_data,
        output req_ready, rsp_valid, rsp_quotient, rsp_err,
        output rsp_cycles, div_in_valid, div_in_data_1, div_in_data_2
    );

    modport master (
        output req_valid, req_dividend, req_divisor,
        output rsp_ready, div_out_valid, div_out_data,
        input  req_ready, rsp_valid, rsp_quotient, rsp_err,
        input  rsp_cycles, div_in_valid, div_in_data_1, div_in_data_2
    );
endinterface

// File: rtl/division_requester.sv
// Host-side driver for the iterative Division block: one job in flight,
// local divide-by-zero handling, operand hold and re-arm guard.
module division_requester #(
    parameter int IN_HOLD = 1,
    parameter int LAT_W   = 8
) (
    input logic clk,
    input logic rst,
    division_requester_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RESP,
        GUARD
    } state_t;

    state_t           state, state_n;
    logic [9:0]       op_a;
    logic [2:0]       op_b;
    logic [3:0]       hold_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             zero_job;
    logic             guard_low;
    logic             req_ready;
    logic             rsp_valid;
    logic             div_in_valid;
    logic [19:0]      quot;
    logic             err;
    logic [LAT_W-1:0] cycles;
    logic             req_fire;
    logic             rsp_fire;
    logic             hold_done;
    logic             div_zero;

    assign req_fire  = bus.req_valid && req_ready && (state == IDLE);
    assign rsp_fire  = rsp_valid && bus.rsp_ready;
    assign hold_done = (hold_cnt == 4'(IN_HOLD));
    assign div_zero  = (bus.req_divisor == 3'd0);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (req_fire) state_n = div_zero ? RESP : SEND;
            SEND:    if (hold_done) state_n = WAIT;
            WAIT:    if (bus.div_out_valid) state_n = RESP;
            RESP:    if (rsp_fire) state_n = zero_job ? IDLE : GUARD;
            GUARD:   if (guard_low) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            hold_cnt     <= '0;
            lat_cnt      <= '0;
            zero_job     <= 1'b0;
            guard_low    <= 1'b0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            div_in_valid <= 1'b0;
            quot         <= '0;
            err          <= 1'b0;
            cycles       <= '0;
        end else begin
            state        <= state_n;
            req_ready    <= (state_n == IDLE);
            rsp_valid    <= (state_n == RESP);
            div_in_valid <= (state_n == SEND);
            if (req_fire) begin
                op_a     <= bus.req_dividend;
                op_b     <= bus.req_divisor;
                hold_cnt <= 4'd1;
                lat_cnt  <= LAT_W'(1);
                zero_job <= div_zero;
                if (div_zero) begin
                    quot   <= 20'hFFFFF;
                    err    <= 1'b1;
                    cycles <= '0;
                end
            end
            if (state == SEND && !hold_done)
                hold_cnt <= hold_cnt + 4'd1;
            if ((state == SEND || state == WAIT) && !(&lat_cnt))
                lat_cnt <= lat_cnt + LAT_W'(1);
            // out_valid stays up two cycles; WAIT is left after the first
            if (state == WAIT && bus.div_out_valid) begin
                quot   <= bus.div_out_data;
                err    <= 1'b0;
                cycles <= lat_cnt;
            end
            if (state == RESP)
                guard_low <= 1'b0;
            if (state == GUARD && !bus.div_out_valid)
                guard_low <= 1'b1;
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.rsp_valid     = rsp_valid;
    assign bus.rsp_quotient  = quot;
    assign bus.rsp_err       = err;
    assign bus.rsp_cycles    = cycles;
    assign bus.div_in_valid  = div_in_valid;
    assign bus.div_in_data_1 = op_a;
    assign bus.div_in_data_2 = op_b;
endmodule

// File: tb/tb_division_requester.sv
// Directed bench for division_requester with a behavioural Division
// model on the far side; expected quotients are hand-computed.
module tb_division_requester;
    localparam int LAT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    division_requester_if #(.LAT_W(LAT_W)) ifc ();

    division_requester #(
        .IN_HOLD(1),
        .LAT_W  (LAT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    // Division model: samples in_data_1 after in_valid falls, exact
    // results finish early, out_valid held two cycles, one init cycle.
    int         m_st = 0;
    int         m_lat = 0;
    logic [2:0] m_d2 = '0;
    logic [19:0] m_q = '0;
    int         viol = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_st              <= 0;
            ifc.div_out_valid <= 1'b0;
            ifc.div_out_data  <= '0;
        end else begin
            case (m_st)
                0: if (ifc.div_in_valid) begin
                    m_st <= 1;
                    m_d2 <= ifc.div_in_data_2;
                end
                1: if (!ifc.div_in_valid) begin
                    m_st <= 2;
                    if (m_d2 == 3'd0) begin
                        m_q   <= 20'hFFFFF;
                        m_lat <= 9;
                        viol  <= viol + 1;
                    end else begin
                        m_q <= 20'((32'(ifc.div_in_data_1) << 10) / 32'(m_d2));
                        m_lat <= (((32'(ifc.div_in_data_1) << 10) % 32'(m_d2)) == 0) ? 2 : 9;
                    end
                end
                2: if (m_lat == 0) begin
                    m_st              <= 3;
                    ifc.div_out_valid <= 1'b1;
                    ifc.div_out_data  <= m_q;
                end else begin
                    m_lat <= m_lat - 1;
                end
                3: m_st <= 4;
                4: begin
                    m_st              <= 5;
                    ifc.div_out_valid <= 1'b0;
                end
                5: m_st <= 0;
                default: m_st <= 0;
            endcase
            if (m_st >= 2 && ifc.div_in_valid)
                viol <= viol + 1;
            if (m_st >= 1 && m_st <= 4 && ifc.div_in_data_2 != m_d2)
                viol <= viol + 1;
        end
    end

    logic piv = 1'b0;
    logic pov = 1'b0;
    int   n_inv = 0;
    int   n_ov = 0;
    int   n_rsp = 0;
    int   t_in = 0;
    int   t_out = 0;
    int   t_fall = 0;

    always @(posedge clk) begin
        piv <= ifc.div_in_valid;
        pov <= ifc.div_out_valid;
        if (ifc.div_in_valid) n_inv <= n_inv + 1;
        if (ifc.div_out_valid) n_ov <= n_ov + 1;
        if (ifc.div_in_valid && !piv) t_in <= cyc;
        if (ifc.div_out_valid && !pov) t_out <= cyc;
        if (!ifc.div_out_valid && pov) t_fall <= cyc;
        if (ifc.rsp_valid && ifc.rsp_ready) n_rsp <= n_rsp + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ifc.req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_rdy"}, 32'(n < 100), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [9:0] a, input logic [2:0] b,
                        input string tag);
        ifc.req_valid    = 1'b1;
        ifc.req_dividend = a;
        ifc.req_divisor  = b;
        wait_ready(tag);
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!ifc.rsp_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_rsp"}, 32'(n < 200), 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int c100;
    int c96;
    int s_inv;
    int s_ov;
    int s_rsp;

    initial begin
        ifc.req_valid    = 1'b0;
        ifc.req_dividend = '0;
        ifc.req_divisor  = '0;
        ifc.rsp_ready    = 1'b0;
        step(3);
        check("rst_req_ready", 32'(ifc.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("rst_quot", 32'(ifc.rsp_quotient), 32'd0);
        check("rst_err", 32'(ifc.rsp_err), 32'd0);
        check("rst_cycles", 32'(ifc.rsp_cycles), 32'd0);
        check("rst_in_valid", 32'(ifc.div_in_valid), 32'd0);
        check("rst_d1", 32'(ifc.div_in_data_1), 32'd0);
        check("rst_d2", 32'(ifc.div_in_data_2), 32'd0);
        rst = 1'b0;
        step(2);
        check("idle_req_ready", 32'(ifc.req_ready), 32'd1);

        // 100/3
        ifc.rsp_ready = 1'b1;
        s_inv = n_inv;
        s_rsp = n_rsp;
        send(10'd100, 3'd3, "j100");
        wait_rsp("j100");
        check("j100_q", 32'(ifc.rsp_quotient), 32'h08555);
        check("j100_err", 32'(ifc.rsp_err), 32'd0);
        check("j100_cyc", 32'(ifc.rsp_cycles), 32'(t_out - t_in + 1));
        c100 = int'(ifc.rsp_cycles);
        step(3);
        check("j100_inv", 32'(n_inv - s_inv), 32'd1);
        check("j100_pulses", 32'(n_rsp - s_rsp), 32'd1);

        // 96/3, exact
        send(10'd96, 3'd3, "j96");
        wait_rsp("j96");
        check("j96_q", 32'(ifc.rsp_quotient), 32'h08000);
        check("j96_cyc", 32'(ifc.rsp_cycles), 32'(t_out - t_in + 1));
        c96 = int'(ifc.rsp_cycles);
        check("j96_shorter", 32'(c96 < c100), 32'd1);
        step(3);

        // 5/0
        s_inv = n_inv;
        send(10'd5, 3'd0, "jz");
        check("jz_next", 32'(ifc.rsp_valid), 32'd1);
        check("jz_q", 32'(ifc.rsp_quotient), 32'hFFFFF);
        check("jz_err", 32'(ifc.rsp_err), 32'd1);
        check("jz_cyc", 32'(ifc.rsp_cycles), 32'd0);
        step(3);
        check("jz_no_inv", 32'(n_inv - s_inv), 32'd0);

        // 1023/7 with backpressure
        ifc.rsp_ready = 1'b0;
        s_ov  = n_ov;
        s_rsp = n_rsp;
        send(10'd1023, 3'd7, "jbp");
        wait_rsp("jbp");
        check("jbp_cyc", 32'(ifc.rsp_cycles), 32'(t_out - t_in + 1));
        for (int i = 0; i < 10; i++) begin
            check("jbp_q", 32'(ifc.rsp_quotient), 32'h24892);
            check("jbp_valid", 32'(ifc.rsp_valid), 32'd1);
            check("jbp_req_ready", 32'(ifc.req_ready), 32'd0);
            step(1);
        end
        check("jbp_ov_cycles", 32'(n_ov - s_ov), 32'd2);
        ifc.rsp_ready = 1'b1;
        step(1);
        check("jbp_drop", 32'(ifc.rsp_valid), 32'd0);
        check("jbp_pulses", 32'(n_rsp - s_rsp), 32'd1);
        step(3);

        // back-to-back with req_valid held
        ifc.req_valid    = 1'b1;
        ifc.req_dividend = 10'd100;
        ifc.req_divisor  = 3'd3;
        wait_ready("b2b1");
        ifc.req_dividend = 10'd50;
        ifc.req_divisor  = 3'd2;
        wait_rsp("b2b1");
        check("b2b1_q", 32'(ifc.rsp_quotient), 32'h08555);
        wait_ready("b2b2");
        ifc.req_valid = 1'b0;
        wait_rsp("b2b2");
        check("b2b2_q", 32'(ifc.rsp_quotient), 32'h06400);
        check("b2b_gap", 32'((t_in - t_fall) >= 2), 32'd1);
        step(4);

        // reset while waiting on Division
        s_rsp = n_rsp;
        send(10'd100, 3'd3, "jrst");
        step(4);
        rst = 1'b1;
        step(1);
        check("jrst_in_valid", 32'(ifc.div_in_valid), 32'd0);
        check("jrst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        rst = 1'b0;
        step(1);
        check("jrst_idle", 32'(ifc.req_ready), 32'd1);
        step(15);
        check("jrst_discard", 32'(n_rsp - s_rsp), 32'd0);
        send(10'd7, 3'd1, "j7");
        wait_rsp("j7");
        check("j7_q", 32'(ifc.rsp_quotient), 32'h01C00);
        check("j7_err", 32'(ifc.rsp_err), 32'd0);
        step(4);

        check("div_protocol", 32'(viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
